// File: rtl/priority_encoder8_3_if.sv
// Request/grant bundle between request sources, the priority encoder and the consumer of A.
// Request lines and enables are active-low; grant, pending and valid outputs are active-high.
interface priority_encoder8_3_if;
  logic       ei_l;
  logic [7:0] i_l;
  logic       ack;
  logic [2:0] a;
  logic       valid;
  logic [7:0] pend;
  logic       gs_l;

  modport master (
    output ei_l, i_l, ack,
    input  a, valid, pend, gs_l
  );

  modport slave (
    input  ei_l, i_l, ack,
    output a, valid, pend, gs_l
  );
endinterface

// File: rtl/priority_encoder8_3.sv
// Registered 8-to-3 priority encoder: latches active-low requests into a pending vector
// and holds the highest pending index on A until the consumer acknowledges it.
module priority_encoder8_3 #(
  parameter int EDGE = 1
) (
  input logic                  clk,
  input logic                  rst,
  priority_encoder8_3_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] prev_req_q, prev_req_d;
  logic [2:0] a_q, a_d;
  logic       valid_q, valid_d;

  logic [7:0] req;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [2:0] hi_idx;
  logic       grant;
  logic       accept;

  assign req = ~bus.i_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 8'h00;
      prev_req_q <= 8'h00;
      a_q        <= 3'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      prev_req_q <= prev_req_d;
      a_q        <= a_d;
      valid_q    <= valid_d;
    end
  end

  // Priority is resolved from the registered snapshot, so bits setting on the grant edge wait.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) hi_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.ei_l && (pend_q != 8'h00)) begin
          grant   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A set arriving on the same cycle as the clear of that bit keeps the bit pending.
  always_comb begin
    prev_req_d = req;
    set_vec    = (EDGE != 0) ? (req & ~prev_req_q) : req;
    clr_vec    = accept ? (8'h01 << a_q) : 8'h00;
    pend_d     = (pend_q & ~clr_vec) | set_vec;
    a_d        = grant ? hi_idx : a_q;
    valid_d    = (state_d == HOLD);
  end

  assign bus.a     = a_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.gs_l  = (pend_q == 8'h00);

endmodule

// File: tb/tb_priority_encoder8_3.sv
// Directed self-checking bench for priority_encoder8_3 in edge mode and level mode.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_priority_encoder8_3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  priority_encoder8_3_if bus_e ();
  priority_encoder8_3_if bus_l ();

  priority_encoder8_3 #(.EDGE(1)) dut_edge (.clk(clk), .rst(rst), .bus(bus_e));
  priority_encoder8_3 #(.EDGE(0)) dut_level (.clk(clk), .rst(rst), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus_e.i_l = 8'hFF; bus_e.ei_l = 1'b0; bus_e.ack = 1'b0;
    bus_l.i_l = 8'hFF; bus_l.ei_l = 1'b0; bus_l.ack = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus_e.a !== 3'd0 || bus_e.valid !== 1'b0 || bus_e.pend !== 8'h00 || bus_e.gs_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset: a=%0d valid=%b pend=%h gs_l=%b, expected a=0 valid=0 pend=00 gs_l=1",
               bus_e.a, bus_e.valid, bus_e.pend, bus_e.gs_l);
    end
    checks++;
    if (bus_l.valid !== 1'b0 || bus_l.pend !== 8'h00 || bus_l.gs_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_level: valid=%b pend=%h gs_l=%b, expected 0 00 1",
               bus_l.valid, bus_l.pend, bus_l.gs_l);
    end
  endtask

  task automatic test_single_grant();
    bus_e.i_l = 8'hDF;
    tick(1);
    checks++;
    if (bus_e.pend !== 8'h20 || bus_e.gs_l !== 1'b0 || bus_e.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pend: pend=%h gs_l=%b valid=%b, expected 20 0 0",
               bus_e.pend, bus_e.gs_l, bus_e.valid);
    end
    tick(1);
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_grant: valid=%b a=%0d, expected 1 5", bus_e.valid, bus_e.a);
    end
    bus_e.i_l = 8'hFF;
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    checks++;
    if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h00 || bus_e.gs_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ack: valid=%b pend=%h gs_l=%b, expected 0 00 1",
               bus_e.valid, bus_e.pend, bus_e.gs_l);
    end
  endtask

  task automatic test_priority();
    bus_e.i_l = 8'hBD;
    tick(2);
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd6 || bus_e.pend !== 8'h42) begin
      errors++;
      $display("[TB] FAIL prio_first: valid=%b a=%0d pend=%h, expected 1 6 42",
               bus_e.valid, bus_e.a, bus_e.pend);
    end
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    checks++;
    if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h02) begin
      errors++;
      $display("[TB] FAIL prio_gap: valid=%b pend=%h, expected 0 02", bus_e.valid, bus_e.pend);
    end
    tick(1);
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd1) begin
      errors++;
      $display("[TB] FAIL prio_second: valid=%b a=%0d, expected 1 1", bus_e.valid, bus_e.a);
    end
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    bus_e.i_l = 8'hFF;
    checks++;
    if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h00) begin
      errors++;
      $display("[TB] FAIL prio_done: valid=%b pend=%h, expected 0 00", bus_e.valid, bus_e.pend);
    end
    tick(1);
  endtask

  task automatic test_no_preempt();
    bus_e.i_l = 8'hFB;
    tick(1);
    bus_e.i_l = 8'hFF;
    tick(3);
    bus_e.i_l = 8'h7B;
    tick(1);
    bus_e.i_l = 8'hFF;
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd2 || bus_e.pend !== 8'h84) begin
      errors++;
      $display("[TB] FAIL hold_frozen: valid=%b a=%0d pend=%h, expected 1 2 84",
               bus_e.valid, bus_e.a, bus_e.pend);
    end
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    checks++;
    if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h80) begin
      errors++;
      $display("[TB] FAIL hold_ack: valid=%b pend=%h, expected 0 80", bus_e.valid, bus_e.pend);
    end
    tick(1);
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd7) begin
      errors++;
      $display("[TB] FAIL hold_next: valid=%b a=%0d, expected 1 7", bus_e.valid, bus_e.a);
    end
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    tick(1);
  endtask

  task automatic test_enable();
    bus_e.ei_l = 1'b1;
    bus_e.i_l  = 8'hF7;
    tick(1);
    bus_e.i_l = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h08) begin
        errors++;
        $display("[TB] FAIL enable_block[%0d]: valid=%b pend=%h, expected 0 08",
                 k, bus_e.valid, bus_e.pend);
      end
      tick(1);
    end
    bus_e.ei_l = 1'b0;
    tick(1);
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd3) begin
      errors++;
      $display("[TB] FAIL enable_grant: valid=%b a=%0d, expected 1 3", bus_e.valid, bus_e.a);
    end
    bus_e.ack = 1'b1;
    tick(1);
    bus_e.ack = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset();
    bus_e.i_l = 8'hEE;
    tick(2);
    bus_e.i_l = 8'hFF;
    checks++;
    if (bus_e.valid !== 1'b1 || bus_e.a !== 3'd4 || bus_e.pend !== 8'h11) begin
      errors++;
      $display("[TB] FAIL areset_setup: valid=%b a=%0d pend=%h, expected 1 4 11",
               bus_e.valid, bus_e.a, bus_e.pend);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_e.valid !== 1'b0 || bus_e.pend !== 8'h00 || bus_e.gs_l !== 1'b1 || bus_e.a !== 3'd0) begin
      errors++;
      $display("[TB] FAIL areset: valid=%b pend=%h gs_l=%b a=%0d, expected 0 00 1 0",
               bus_e.valid, bus_e.pend, bus_e.gs_l, bus_e.a);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_level_regrant();
    bus_l.i_l = 8'hEF;
    tick(2);
    checks++;
    if (bus_l.valid !== 1'b1 || bus_l.a !== 3'd4 || bus_l.pend !== 8'h10) begin
      errors++;
      $display("[TB] FAIL level_grant: valid=%b a=%0d pend=%h, expected 1 4 10",
               bus_l.valid, bus_l.a, bus_l.pend);
    end
    bus_l.ack = 1'b1;
    tick(1);
    bus_l.ack = 1'b0;
    checks++;
    if (bus_l.valid !== 1'b0 || bus_l.pend !== 8'h10) begin
      errors++;
      $display("[TB] FAIL level_setwins: valid=%b pend=%h, expected 0 10", bus_l.valid, bus_l.pend);
    end
    tick(1);
    checks++;
    if (bus_l.valid !== 1'b1 || bus_l.a !== 3'd4) begin
      errors++;
      $display("[TB] FAIL level_regrant: valid=%b a=%0d, expected 1 4", bus_l.valid, bus_l.a);
    end
    bus_l.i_l = 8'hFF;
    bus_l.ack = 1'b1;
    tick(1);
    bus_l.ack = 1'b0;
    checks++;
    if (bus_l.valid !== 1'b0 || bus_l.pend !== 8'h00 || bus_l.gs_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL level_release: valid=%b pend=%h gs_l=%b, expected 0 00 1",
               bus_l.valid, bus_l.pend, bus_l.gs_l);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_grant();
    test_priority();
    test_no_preempt();
    test_enable();
    test_async_reset();
    test_level_regrant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
